// File: rtl/bam_prod_accum_if.sv
// Handshake bundle for bam_prod_accum: product input stream and frame-result output stream.
// The master side drives products and out_ready; the slave side is the accumulator.
interface bam_prod_accum_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24
) ();
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [8:0]        out_count;
  logic              out_sat;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat
  );
endinterface

// File: rtl/bam_prod_accum.sv
// Saturating frame accumulator for approximate-multiplier products (IDLE -> ACC -> DONE).
// Optional per-term bias compensation is enabled with macro BAM_BIAS_COMP_EN.
module bam_prod_accum #(
  parameter int          PROD_W = 16,
  parameter int          ACC_W  = 24,
  parameter int          LEN    = 16,
  parameter int unsigned BIAS   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  bam_prod_accum_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [8:0] LEN_C = 9'(LEN);

  generate
    if ((ACC_W < PROD_W) || (LEN < 1) || (LEN > 256) ||
        (64'(BIAS) >= (64'd1 << PROD_W))) begin : g_param_chk
      $error("bam_prod_accum: illegal parameter combination");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [8:0]         cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               ready_q, ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [8:0]         out_count_q, out_count_d;
  logic               out_sat_q, out_sat_d;

  logic [PROD_W:0]    term_s;
  logic [ACC_W:0]     term_ext_s;
  logic [ACC_W-1:0]   base_acc_s;
  logic               base_sat_s;
  logic [ACC_W:0]     sum_s;
  logic [ACC_W-1:0]   nxt_acc_s;
  logic               nxt_sat_s;
  logic [8:0]         nxt_cnt_s;
  logic               accept_s;

`ifdef BAM_BIAS_COMP_EN
  // Bias is added before accumulation to offset the truncated multiplier's negative mean error.
  assign term_s = {1'b0, bus.in_prod} + {1'b0, PROD_W'(BIAS)};
`else
  assign term_s = {1'b0, bus.in_prod};
`endif

  assign term_ext_s    = (ACC_W+1)'(term_s);
  assign accept_s      = bus.in_valid & bus.in_ready;

  assign bus.in_ready  = rst_n & ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_sat   = out_sat_q;

  // Saturating add of the incoming term; a frame's first term starts from zero.
  always_comb begin
    base_acc_s = {ACC_W{1'b0}};
    base_sat_s = 1'b0;
    nxt_cnt_s  = 9'd1;
    if (state_q == S_ACC) begin
      base_acc_s = acc_q;
      base_sat_s = sat_q;
      nxt_cnt_s  = cnt_q + 9'd1;
    end else begin
      base_acc_s = {ACC_W{1'b0}};
      base_sat_s = 1'b0;
      nxt_cnt_s  = 9'd1;
    end
    sum_s = {1'b0, base_acc_s} + term_ext_s;
    if (sum_s[ACC_W] || base_sat_s) begin
      nxt_acc_s = {ACC_W{1'b1}};
      nxt_sat_s = 1'b1;
    end else begin
      nxt_acc_s = sum_s[ACC_W-1:0];
      nxt_sat_s = 1'b0;
    end
  end

  // Frame sequencing; result registers load on DONE entry and clear on transfer.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    ready_d     = ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (accept_s) begin
          acc_d = nxt_acc_s;
          cnt_d = nxt_cnt_s;
          sat_d = nxt_sat_s;
          if (bus.in_last || (nxt_cnt_s == LEN_C)) begin
            state_d     = S_DONE;
            ready_d     = 1'b0;
            out_valid_d = 1'b1;
            out_sum_d   = nxt_acc_s;
            out_count_d = nxt_cnt_s;
            out_sat_d   = nxt_sat_s;
          end else begin
            state_d = S_ACC;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          acc_d       = {ACC_W{1'b0}};
          cnt_d       = 9'd0;
          sat_d       = 1'b0;
          ready_d     = 1'b1;
          out_valid_d = 1'b0;
          out_sum_d   = {ACC_W{1'b0}};
          out_count_d = 9'd0;
          out_sat_d   = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d     = S_IDLE;
        acc_d       = {ACC_W{1'b0}};
        cnt_d       = 9'd0;
        sat_d       = 1'b0;
        ready_d     = 1'b1;
        out_valid_d = 1'b0;
        out_sum_d   = {ACC_W{1'b0}};
        out_count_d = 9'd0;
        out_sat_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= 9'd0;
      sat_q       <= 1'b0;
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= {ACC_W{1'b0}};
      out_count_q <= 9'd0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule
